// File: rtl/mutex_arb_n.sv
// N-way clocked mutual-exclusion arbiter with optional request synchronisers.
// Fixed-priority or round-robin winner selection; a grant holds until its request drops.
module mutex_arb_n #(
    parameter int unsigned N           = 4,
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned OW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          busy,
    output logic [OW-1:0] owner
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_nxt;
    logic [N-1:0]  w_req_s;
    logic [N-1:0]  w_rot;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] w_owner_nxt;
    logic [OW-1:0] w_win;
    logic          w_found;
    logic          w_hold;

    // Per-bit synchroniser chain; bits are independent, no cross-bit coherence.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_req_s = req;
        end else begin : g_sync
            logic [N-1:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                        r_sync[i] <= '0;
                    end
                end else begin
                    r_sync[0] <= req;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_req_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Rotate so bit 0 is the channel just after the last winner, then take the lowest set bit.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_rot   = (ROUND_ROBIN != 0)
                ? N'({w_req_s, w_req_s} >> ((32'(r_owner) + 32'd1) % N))
                : w_req_s;
        for (int i = 0; i < int'(N); i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_win   = (ROUND_ROBIN != 0)
                        ? OW'((32'(r_owner) + 32'(i) + 32'd1) % N)
                        : OW'(i);
            end
        end
    end

    assign w_hold = |(w_req_s & r_gnt);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = N'(1) << w_win;
                    w_owner_nxt = w_win;
                end
            end
            GRANT: begin
                if (!w_hold) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign busy  = |r_gnt;
    assign owner = r_owner;

endmodule

// File: tb/tb_mutex_arb_n.sv
// Randomised and directed bench for mutex_arb_n over several N/policy/sync configurations,
// checked every cycle against a queue-free behavioural arbiter model.
module tb_mutex_arb_n;

    localparam int NI = 5;

    function automatic int unsigned cfg_n(input int c);
        case (c)
            0: return 4;
            1: return 4;
            2: return 3;
            3: return 5;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned cfg_rr(input int c);
        case (c)
            0: return 1;
            1: return 0;
            2: return 1;
            3: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned cfg_s(input int c);
        case (c)
            0: return 2;
            1: return 0;
            2: return 1;
            3: return 3;
            default: return 2;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_a   [NI];
    wire  [7:0] gnt_a   [NI];
    wire  [7:0] owner_a [NI];
    wire        busy_a  [NI];

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar c = 0; c < NI; c++) begin : g_dut
        localparam int unsigned CN  = cfg_n(c);
        localparam int unsigned COW = (CN > 1) ? $clog2(CN) : 1;
        wire [CN-1:0]  w_gnt;
        wire [COW-1:0] w_owner;
        wire           w_busy;

        mutex_arb_n #(
            .N          (CN),
            .ROUND_ROBIN(cfg_rr(c)),
            .SYNC_STAGES(cfg_s(c))
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .req  (req_a[c][CN-1:0]),
            .gnt  (w_gnt),
            .busy (w_busy),
            .owner(w_owner)
        );

        assign gnt_a[c]   = 8'(w_gnt);
        assign owner_a[c] = 8'(w_owner);
        assign busy_a[c]  = w_busy;
    end

    // Behavioural model: delayed request samples, current holder (-1 = none), last winner.
    logic [7:0] m_hist [NI][4];
    int         m_cur  [NI];
    int         m_own  [NI];

    task automatic model_reset();
        for (int c = 0; c < NI; c++) begin
            m_cur[c] = -1;
            m_own[c] = 0;
            for (int k = 0; k < 4; k++) m_hist[c][k] = 8'h00;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NI; c++) begin
            int         n;
            int         s;
            int         w;
            logic [7:0] rs;
            n = int'(cfg_n(c));
            s = int'(cfg_s(c));
            rs = (s == 0) ? req_a[c] : m_hist[c][s-1];
            for (int k = 3; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
            m_hist[c][0] = req_a[c];
            if (m_cur[c] >= 0) begin
                if (!rs[m_cur[c]]) m_cur[c] = -1;
            end else begin
                w = -1;
                for (int k = 1; k <= n; k++) begin
                    int idx;
                    idx = (cfg_rr(c) != 0) ? (m_own[c] + k) % n : k - 1;
                    if (w < 0 && rs[idx]) w = idx;
                end
                if (w >= 0) begin
                    m_cur[c] = w;
                    m_own[c] = w;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h, expected %h at %0t", name, c, act, exp, $time);
        end
    endtask

    logic [7:0] cmp_eg;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NI; c++) begin
                cmp_eg = (m_cur[c] < 0) ? 8'h00 : (8'd1 << m_cur[c]);
                chk("model_gnt", c, gnt_a[c], cmp_eg);
                chk("model_busy", c, {7'd0, busy_a[c]}, {7'd0, (m_cur[c] >= 0)});
                chk("model_owner", c, owner_a[c], 8'(m_own[c]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int c, input logic [7:0] val, input bit want_eq, input string name);
        int n;
        n = 0;
        while (((gnt_a[c] === val) != want_eq) && n < 40) begin
            step(1);
            n++;
        end
        if (n >= 40) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s inst%0d: timeout, gnt=%h", name, c, gnt_a[c]);
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int c = 0; c < NI; c++) req_a[c] = 8'h00;
        step(2);
        for (int c = 0; c < NI; c++) begin
            chk("rst_gnt", c, gnt_a[c], 8'h00);
            chk("rst_busy", c, {7'd0, busy_a[c]}, 8'h00);
            chk("rst_owner", c, owner_a[c], 8'h00);
        end
        chk_en = 1'b1;
        rst = 1'b1;
        step(1);

        // Single request latency (S=2): three edges each way.
        req_a[0] = 8'h04;
        step(2);
        chk("lat_rise_early", 0, gnt_a[0], 8'h00);
        step(1);
        chk("lat_rise", 0, gnt_a[0], 8'h04);
        chk("lat_owner", 0, owner_a[0], 8'h02);
        req_a[0] = 8'h00;
        step(2);
        chk("lat_fall_early", 0, gnt_a[0], 8'h04);
        step(1);
        chk("lat_fall", 0, gnt_a[0], 8'h00);
        chk("lat_owner_kept", 0, owner_a[0], 8'h02);

        // Non-pre-emption.
        req_a[0] = 8'h01;
        step(3);
        chk("np_gnt0", 0, gnt_a[0], 8'h01);
        req_a[0] = 8'h09;
        step(5);
        chk("np_hold", 0, gnt_a[0], 8'h01);
        req_a[0] = 8'h08;
        step(3);
        chk("np_gap", 0, gnt_a[0], 8'h00);
        step(1);
        chk("np_gnt3", 0, gnt_a[0], 8'h08);
        chk("np_owner3", 0, owner_a[0], 8'h03);
        req_a[0] = 8'h00;
        step(3);
        chk("np_release", 0, gnt_a[0], 8'h00);

        // Round-robin fairness from owner 3: order 0,1,2,3,0,...
        req_a[0] = 8'h0F;
        for (int k = 0; k < 8; k++) begin
            int exp_idx;
            exp_idx = k % 4;
            wait_gnt(0, 8'h00, 1'b0, "rr_wait");
            chk("rr_order", 0, gnt_a[0], 8'd1 << exp_idx);
            step(1);
            req_a[0][exp_idx] = 1'b0;
            wait_gnt(0, 8'd1 << exp_idx, 1'b0, "rr_fall");
            chk("rr_gap", 0, gnt_a[0], 8'h00);
            req_a[0][exp_idx] = 1'b1;
        end
        req_a[0] = 8'h00;
        wait_gnt(0, 8'h00, 1'b1, "rr_drain");

        // Fixed priority (S=0): channel 1 keeps returning, channel 3 starves.
        req_a[1] = 8'h0A;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(1, 8'h00, 1'b0, "fx_wait");
            chk("fx_gnt", 1, gnt_a[1], 8'h02);
            chk("fx_owner", 1, owner_a[1], 8'h01);
            step(1);
            req_a[1] = 8'h08;
            wait_gnt(1, 8'h02, 1'b0, "fx_fall");
            chk("fx_gap", 1, gnt_a[1], 8'h00);
            req_a[1] = 8'h0A;
        end
        req_a[1] = 8'h00;
        step(4);

        // Asynchronous reset in the middle of a grant.
        req_a[0] = 8'h02;
        wait_gnt(0, 8'h02, 1'b1, "mr_wait");
        #2;
        rst = 1'b0;
        #1;
        chk("mr_gnt", 0, gnt_a[0], 8'h00);
        chk("mr_busy", 0, {7'd0, busy_a[0]}, 8'h00);
        chk("mr_owner", 0, owner_a[0], 8'h00);
        step(2);
        rst = 1'b1;
        step(2);
        chk("mr_early", 0, gnt_a[0], 8'h00);
        step(1);
        chk("mr_regrant", 0, gnt_a[0], 8'h02);
        chk("mr_owner1", 0, owner_a[0], 8'h01);
        req_a[0] = 8'h00;
        wait_gnt(0, 8'h00, 1'b1, "mr_drain");

        // After reset the round-robin scan starts at index 1; fixed picks index 0.
        rst = 1'b0;
        step(1);
        req_a[0] = 8'h09;
        req_a[1] = 8'h09;
        rst = 1'b1;
        step(3);
        chk("rr_start_gnt", 0, gnt_a[0], 8'h08);
        chk("rr_start_owner", 0, owner_a[0], 8'h03);
        chk("fx_start_gnt", 1, gnt_a[1], 8'h01);
        req_a[0] = 8'h00;
        req_a[1] = 8'h00;
        step(6);

        // Random toggles on every instance, with one asynchronous reset mid-run.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int c = 0; c < NI; c++) begin
                for (int b = 0; b < int'(cfg_n(c)); b++) begin
                    if ($urandom_range(0, 5) == 0) req_a[c][b] = ~req_a[c][b];
                end
            end
            if (cyc == 5000) begin
                rst = 1'b0;
                step(2);
                rst = 1'b1;
            end
            step(1);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
